icache_ctrl: RTL and testbench

// Direct-mapped instruction cache between the fetch stage and the memory controller.

---
 rtl/icache_ctrl_if.sv | 23 ++
 rtl/icache_ctrl.sv | 149 ++++++++++++++
 tb/tb_icache_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side buses of the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the view of the CPU/memory environment.
interface icache_ctrl_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave (
    input  imemREN, imemaddr, iflush, iload, iwait,
    output imemload, ihit, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iflush, iload, iwait,
    input  imemload, ihit, iREN, iaddr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-frame instruction cache controller with a two-state
// miss FSM (IDLE/FETCH) and saturating hit/miss statistics counters.
module icache_ctrl #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      data_d [SETS];
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic [SETS-1:0]  fill_mask_s;
  logic             hit_s;
  logic             fill_s;
  logic             unused_addr_lsb_s;

  assign req_idx_s  = bus.imemaddr[IDX_W+1:2];
  assign req_tag_s  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx_s = miss_addr_q[IDX_W+1:2];
  assign fill_tag_s = miss_addr_q[31:IDX_W+2];

  // Byte offset within the fetched word has no meaning for a word cache.
  assign unused_addr_lsb_s = ^bus.imemaddr[1:0];

  // Lookup: a hit needs a valid matching frame, an idle FSM and no flush in progress.
  always_comb begin
    hit_s = 1'b0;
    if (bus.imemREN && !bus.iflush && (state_q == IDLE) &&
        valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // ihit depends only on registered frame state and fetch inputs, never on iload/iwait.
  assign bus.ihit     = hit_s;
  assign bus.imemload = hit_s ? data_q[req_idx_s] : 32'h0000_0000;
  assign bus.iREN     = (state_q == FETCH);
  assign bus.iaddr    = (state_q == FETCH) ? miss_addr_q : 32'h0000_0000;

  // Miss FSM next-state: a fill completes on the first FETCH edge with iwait low.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit_s && !bus.iflush) begin
          state_d     = FETCH;
          miss_addr_d = {bus.imemaddr[31:2], 2'b00};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!bus.iwait) begin
          state_d = IDLE;
          fill_s  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame update: fill the indexed frame; a simultaneous flush still leaves it invalid.
  always_comb begin
    fill_mask_s = {SETS{1'b0}};
    fill_mask_s[fill_idx_s] = fill_s;
    valid_d = bus.iflush ? {SETS{1'b0}} : (valid_q | fill_mask_s);
    for (int i = 0; i < SETS; i++) begin
      tag_d[i]  = fill_mask_s[i] ? fill_tag_s : tag_q[i];
      data_d[i] = fill_mask_s[i] ? bus.iload  : data_q[i];
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_s && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      hit_count_d = hit_count_q;
    end
    if (fill_s && (miss_count_q != {CNT_W{1'b1}})) begin
      miss_count_d = miss_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // Control state, valid bits, miss address and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= {SETS{1'b0}};
      miss_addr_q  <= 32'h0000_0000;
      hit_count_q  <= {CNT_W{1'b0}};
      miss_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data storage is only meaningful behind a valid bit, so it needs no reset; a fill racing reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized traffic,
// all checked against a word-address-level cache model.
module tb_icache_ctrl;
  localparam int SETS  = 16;
  localparam int CNT_W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  icache_ctrl_if bus();
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  icache_ctrl #(.SETS(SETS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc_n   = 0;

  // Model: each frame remembers which word address it holds and its data.
  logic        m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  logic        busy;
  logic [31:0] pend;
  logic [31:0] m_hits, m_miss;

  logic        s_req, s_flush, s_wt;
  logic [31:0] s_addr, s_load;
  logic        e_hit, e_iren;
  logic [31:0] e_iaddr, e_load;

  task model_clear();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0; m_word[i] = 30'd0; m_data[i] = 32'd0;
    end
    busy = 1'b0; pend = 32'd0; m_hits = 32'd0; m_miss = 32'd0;
  endtask

  task apply(input logic req, input logic [31:0] addr, input logic flush,
             input logic wt, input logic [31:0] load);
    int idx;
    s_req = req; s_addr = addr; s_flush = flush; s_wt = wt; s_load = load;
    bus.imemREN = req; bus.imemaddr = addr; bus.iflush = flush;
    bus.iwait = wt; bus.iload = load;
    idx = int'((addr >> 2) % SETS);
    if (!busy) begin
      e_hit   = req && !flush && m_valid[idx] && (m_word[idx] == addr[31:2]);
      e_load  = e_hit ? m_data[idx] : 32'd0;
      e_iren  = 1'b0;
      e_iaddr = 32'd0;
    end else begin
      e_hit = 1'b0; e_load = 32'd0; e_iren = 1'b1; e_iaddr = pend;
    end
    #1;
  endtask

  task advance();
    int fi;
    if (e_hit) m_hits = m_hits + 32'd1;
    if (busy && !s_wt) begin
      fi = int'((pend >> 2) % SETS);
      m_valid[fi] = 1'b1; m_word[fi] = pend[31:2]; m_data[fi] = s_load;
      m_miss = m_miss + 32'd1;
      busy = 1'b0;
    end else if (!busy && s_req && !e_hit && !s_flush) begin
      busy = 1'b1;
      pend = {s_addr[31:2], 2'b00};
    end
    if (s_flush) for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    @(posedge CLK); #1;
    cyc_n++;
  endtask

  task do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_clear();
  endtask

  task test_reset();
    bus.imemREN = 1'b0; bus.imemaddr = 32'd0; bus.iflush = 1'b0; bus.iwait = 1'b1; bus.iload = 32'd0;
    do_reset();
    apply(1'b0, 32'h40, 1'b0, 1'b1, 32'd0);
    vectors++;
    if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload, hit_count, miss_count} !== {1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset: ihit/iREN/iaddr/imemload/hits/misses = %b/%b/%h/%h/%0d/%0d, expected all zero",
               bus.ihit, bus.iREN, bus.iaddr, bus.imemload, hit_count, miss_count);
    end
    advance();
  endtask

  task test_miss_fill();
    for (int c = 1; c <= 5; c++) begin
      apply(1'b1, 32'h40, 1'b0, (c == 2 || c == 3), 32'hDEAD_BEEF);
      vectors++;
      if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload} !== {e_hit, e_iren, e_iaddr, e_load} ||
          bus.iREN !== (c >= 2 && c <= 4) || bus.ihit !== (c == 5)) begin
        errors++;
        $display("FAIL miss_fill c%0d: ihit/iREN/iaddr/imemload = %b/%b/%h/%h, expected %b/%b/%h/%h",
                 c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, e_hit, e_iren, e_iaddr, e_load);
      end
      if (c == 5) begin
        vectors++;
        if (bus.imemload !== 32'hDEAD_BEEF || miss_count !== 32'd1) begin
          errors++;
          $display("FAIL miss_fill_data: imemload=%h miss_count=%0d, expected deadbeef and 1", bus.imemload, miss_count);
        end
      end
      advance();
    end
  endtask

  task test_hit_hold();
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, 32'h40 | 32'(c % 4), 1'b0, 1'b1, 32'h1234_5678);
      vectors++;
      if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0 || bus.imemload !== 32'hDEAD_BEEF || hit_count !== m_hits) begin
        errors++;
        $display("FAIL hit_hold c%0d: ihit/iREN/imemload/hits = %b/%b/%h/%0d, expected 1/0/deadbeef/%0d",
                 c, bus.ihit, bus.iREN, bus.imemload, hit_count, m_hits);
      end
      advance();
    end
  endtask

  task test_conflict();
    logic [31:0] seq [2];
    seq[0] = 32'h80; seq[1] = 32'h40;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        apply(1'b1, seq[k], 1'b0, (c == 1), $urandom);
        vectors++;
        if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload} !== {e_hit, e_iren, e_iaddr, e_load} ||
            (c == 0 && bus.ihit !== 1'b0)) begin
          errors++;
          $display("FAIL conflict %h c%0d: ihit/iREN/iaddr/imemload = %b/%b/%h/%h, expected %b/%b/%h/%h",
                   seq[k], c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, e_hit, e_iren, e_iaddr, e_load);
        end
        advance();
      end
    end
    vectors++;
    if (miss_count !== 32'd3 || miss_count !== m_miss) begin
      errors++;
      $display("FAIL conflict_misses: miss_count=%0d, expected 3", miss_count);
    end
  endtask

  task test_redirect();
    logic [31:0] a;
    for (int c = 0; c < 7; c++) begin
      a = (c == 0 || c == 6) ? 32'h44 : 32'h100;
      apply(1'b1, a, 1'b0, (c == 1), 32'hC0DE_0000 + 32'(c));
      vectors++;
      if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload} !== {e_hit, e_iren, e_iaddr, e_load} ||
          ((c == 1 || c == 2) && bus.iaddr !== 32'h44) || (c == 3 && bus.ihit !== 1'b0) ||
          (c == 6 && bus.ihit !== 1'b1)) begin
        errors++;
        $display("FAIL redirect c%0d: ihit/iREN/iaddr/imemload = %b/%b/%h/%h, expected %b/%b/%h/%h",
                 c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, e_hit, e_iren, e_iaddr, e_load);
      end
      advance();
    end
  endtask

  task test_flush_fill();
    logic [31:0] a;
    for (int c = 0; c < 12; c++) begin
      a = (c < 5) ? 32'h200 : 32'h44;
      apply(1'b1, a, (c == 1 || c == 8), 1'b0, $urandom);
      vectors++;
      if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload} !== {e_hit, e_iren, e_iaddr, e_load} ||
          ((c == 2 || c == 5 || c == 8) && bus.ihit !== 1'b0) || (c == 9 && bus.iREN !== 1'b0)) begin
        errors++;
        $display("FAIL flush_fill c%0d: ihit/iREN/iaddr/imemload = %b/%b/%h/%h, expected %b/%b/%h/%h",
                 c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, e_hit, e_iren, e_iaddr, e_load);
      end
      advance();
    end
  endtask

  task test_reset_mid_fetch();
    apply(1'b1, 32'h300, 1'b0, 1'b1, 32'd0);
    advance();
    apply(1'b1, 32'h300, 1'b0, 1'b1, 32'd0);
    vectors++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h300) begin
      errors++;
      $display("FAIL rst_fetch_pre: iREN/iaddr = %b/%h, expected 1/00000300", bus.iREN, bus.iaddr);
    end
    do_reset();
    apply(1'b0, 32'h300, 1'b0, 1'b1, 32'd0);
    vectors++;
    if ({bus.iREN, bus.iaddr, hit_count, miss_count} !== {1'b0, 32'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL rst_fetch_post: iREN/iaddr/hits/misses = %b/%h/%0d/%0d, expected 0/0/0/0",
               bus.iREN, bus.iaddr, hit_count, miss_count);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 32'h300, 1'b0, 1'b0, 32'hFACE_0001);
      vectors++;
      if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload} !== {e_hit, e_iren, e_iaddr, e_load} ||
          bus.ihit !== (c == 2)) begin
        errors++;
        $display("FAIL rst_refill c%0d: ihit/iREN/iaddr/imemload = %b/%b/%h/%h, expected %b/%b/%h/%h",
                 c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, e_hit, e_iren, e_iaddr, e_load);
      end
      advance();
    end
  endtask

  task test_random();
    logic [31:0] a;
    for (int c = 0; c < 400; c++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      apply($urandom_range(0, 3) != 0, a, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, $urandom);
      vectors++;
      if ({bus.ihit, bus.iREN, bus.iaddr, bus.imemload, hit_count, miss_count} !==
          {e_hit, e_iren, e_iaddr, e_load, m_hits, m_miss}) begin
        errors++;
        $display("FAIL random c%0d: ihit/iREN/iaddr/imemload/hits/misses = %b/%b/%h/%h/%0d/%0d, expected %b/%b/%h/%h/%0d/%0d",
                 c, bus.ihit, bus.iREN, bus.iaddr, bus.imemload, hit_count, miss_count,
                 e_hit, e_iren, e_iaddr, e_load, m_hits, m_miss);
      end
      advance();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_miss_fill();
    test_hit_hold();
    test_conflict();
    test_redirect();
    test_flush_fill();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
